// File: rtl/temp_ramp_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// temp_ramp_sequencer_pkg
// Shared definitions for the temperature ramp sequencer:
//   - state_e      : FSM state encoding (IDLE, LOAD, WAIT, EVAL, STEP, DONE)
//   - ST_*         : status codes reported on the status output
//   - TIMER_W      : width of the inter-command wait counter
//   - flags_onehot : true when exactly one of {negative, positive, zero} is set
// -----------------------------------------------------------------------------
package temp_ramp_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_EVAL = 3'd3,
    S_STEP = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_FAULT   = 2'b10;

  localparam int TIMER_W = 8;

  // Flags are ordered {negative, positive, zero}.
  function automatic logic flags_onehot(input logic [2:0] flags);
    return (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
  endfunction

endpackage

// File: rtl/temp_ramp_sequencer_wait.sv
// -----------------------------------------------------------------------------
// ramp_wait_timer
// Down-counter pacing the WAIT state. Loaded with TICK_DIV while the sequencer
// issues a command (LOAD or STEP), decremented during WAIT; tc_o marks the last
// WAIT cycle so WAIT lasts exactly TICK_DIV cycles.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   load_i in  reload counter with TICK_DIV
//   en_i   in  count down one step
//   tc_o   out terminal count (counter == 1)
// -----------------------------------------------------------------------------
module ramp_wait_timer
  import temp_ramp_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(TICK_DIV);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  // Next count: reload on a command, count down while waiting, saturate at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != {TIMER_W{1'b0}})) begin
      cnt_d = cnt_q - {{(TIMER_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {TIMER_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == {{(TIMER_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/temp_ramp_sequencer.sv
// -----------------------------------------------------------------------------
// temp_ramp_sequencer
// Drives a signed 8-bit temperature register: loads a start offset, then steps
// it one unit at a time toward zero, pacing each command with a TICK_DIV-cycle
// wait so the register flags have settled before they are evaluated.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   start, abort             start request (IDLE only), level abort
//   data_in[7:0]             signed offset captured on accepted start
//   negative/positive/zero   register flags
//   load/increment/decrement register strobes (registered, at most one high)
//   data[7:0]                captured offset presented to the register
//   busy, done               not-IDLE indicator, one-cycle completion pulse
//   status[1:0]              00 ok, 01 timeout, 10 flag fault
//   step_count[7:0]          increment/decrement strobes in current/last ramp
// -----------------------------------------------------------------------------
module temp_ramp_sequencer
  import temp_ramp_sequencer_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int MAX_STEPS = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] data_in,
  input  logic       negative,
  input  logic       positive,
  input  logic       zero,
  output logic       load,
  output logic       increment,
  output logic       decrement,
  output logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic [7:0] step_count
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_STEPS);

  state_e     state_q, state_d;
  logic       load_q, load_d;
  logic       inc_q, inc_d;
  logic       dec_q, dec_d;
  logic [7:0] data_q, data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [1:0] status_q, status_d;
  logic [7:0] step_q, step_d;

  logic       timer_load;
  logic       timer_en;
  logic       timer_tc;
  logic [2:0] flags;

  assign flags = {negative, positive, zero};

  // The wait timer is armed during every command cycle so WAIT starts full.
  assign timer_load = (state_q == S_LOAD) || (state_q == S_STEP);
  assign timer_en   = (state_q == S_WAIT);

  ramp_wait_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_wait (
    .clk    (clk),
    .reset  (reset),
    .load_i (timer_load),
    .en_i   (timer_en),
    .tc_o   (timer_tc)
  );

  // Next-state and next-output logic; strobes are computed one cycle ahead so
  // they appear registered in the LOAD/STEP cycle itself.
  always_comb begin
    state_d  = state_q;
    load_d   = 1'b0;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    done_d   = 1'b0;
    data_d   = data_q;
    status_d = status_q;
    step_d   = step_q;

    if (abort) begin
      // Abort beats start in IDLE and leaves status/step_count untouched.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            data_d   = data_in;
            step_d   = 8'd0;
            status_d = ST_OK;
            load_d   = 1'b1;
            state_d  = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (timer_tc) begin
            state_d = S_EVAL;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_EVAL: begin
          // Zero is checked before the step limit so a ramp that lands exactly
          // on MAX_STEPS still reports ok.
          if (!flags_onehot(flags)) begin
            status_d = ST_FAULT;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else if (zero) begin
            status_d = ST_OK;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else if (step_q == MAX_CNT) begin
            status_d = ST_TIMEOUT;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else if (positive) begin
            dec_d   = 1'b1;
            step_d  = step_q + 8'd1;
            state_d = S_STEP;
          end else begin
            inc_d   = 1'b1;
            step_d  = step_q + 8'd1;
            state_d = S_STEP;
          end
        end
        S_STEP: begin
          state_d = S_WAIT;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      load_q   <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      data_q   <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= ST_OK;
      step_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      load_q   <= load_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      status_q <= status_d;
      step_q   <= step_d;
    end
  end

  assign load       = load_q;
  assign increment  = inc_q;
  assign decrement  = dec_q;
  assign data       = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign status     = status_q;
  assign step_count = step_q;

endmodule

// File: tb/tb_temp_ramp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_temp_ramp_sequencer
// Scoreboard bench: a behavioural temperature register drives the flags; each
// accepted start pushes the expected ramp outcome (computed from |offset| and
// the step limit) into a queue, and a monitor pops and checks on every done.
// -----------------------------------------------------------------------------
module tb_temp_ramp_sequencer;

  localparam int T    = 4;
  localparam int MAXS = 20;
  localparam int P    = T + 2;

  typedef struct {
    int         start_cyc;
    int         n;
    bit         up;
    logic [1:0] status;
    int         fin;
    logic [7:0] v;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] data_in;
  logic       negative, positive, zero;
  logic       load, increment, decrement;
  logic [7:0] data;
  logic       busy, done;
  logic [1:0] status;
  logic [7:0] step_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  exp_t exp_q[$];

  // behavioural register and flag pipeline
  logic signed [7:0] reg_val = 8'sd0;
  logic [2:0]        flag_q  = 3'b001;
  bit                force_en  = 1'b0;
  logic [2:0]        force_val = 3'b000;

  int r_k = 0, r_inc = 0, r_dec = 0, r_space_err = 0;
  int tot_load = 0, tot_inc = 0, tot_dec = 0;

  temp_ramp_sequencer #(
    .TICK_DIV  (T),
    .MAX_STEPS (MAXS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .data_in    (data_in),
    .negative   (negative),
    .positive   (positive),
    .zero       (zero),
    .load       (load),
    .increment  (increment),
    .decrement  (decrement),
    .data       (data),
    .busy       (busy),
    .done       (done),
    .status     (status),
    .step_count (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (load)           reg_val <= data;
    else if (increment) reg_val <= reg_val + 8'sd1;
    else if (decrement) reg_val <= reg_val - 8'sd1;
    flag_q <= {reg_val < 8'sd0, reg_val > 8'sd0, reg_val == 8'sd0};
  end

  assign {negative, positive, zero} = force_en ? force_val : flag_q;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a ramp needs |v| unit steps toward zero, capped by MAXS.
  function automatic exp_t model(input logic [7:0] v, input int s);
    exp_t m;
    int sv, mag;
    sv  = int'($signed(v));
    mag = (sv < 0) ? -sv : sv;
    m.start_cyc = s;
    m.v         = v;
    m.up        = (sv < 0);
    m.n         = (mag > MAXS) ? MAXS : mag;
    m.status    = (mag > MAXS) ? 2'b01 : 2'b00;
    m.fin       = (sv < 0) ? sv + m.n : sv - m.n;
    return m;
  endfunction

  // Monitor: strobe bookkeeping and scoreboard comparison on done.
  always @(negedge clk) begin
    if (!reset) begin
      if ((int'(load) + int'(increment) + int'(decrement)) != 0) begin
        chk("one_strobe", int'(load) + int'(increment) + int'(decrement), 1);
      end
      if (load) begin
        tot_load++;
        r_k = 0; r_inc = 0; r_dec = 0; r_space_err = 0;
        if (exp_q.size() > 0) chk("load_cycle", cyc, exp_q[0].start_cyc + 1);
      end
      if (increment || decrement) begin
        r_k++;
        if (increment) begin r_inc++; tot_inc++; end
        if (decrement) begin r_dec++; tot_dec++; end
        if (exp_q.size() > 0 && cyc != exp_q[0].start_cyc + 1 + r_k * P) r_space_err++;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("status",     int'(status), int'(e.status));
          chk("step_count", int'(step_count), e.n);
          chk("inc_count",  r_inc, e.up ? e.n : 0);
          chk("dec_count",  r_dec, e.up ? 0 : e.n);
          chk("step_space", r_space_err, 0);
          chk("done_cycle", cyc, e.start_cyc + 1 + (e.n + 1) * P);
          chk("reg_final",  int'(reg_val), e.fin);
          chk("data_out",   int'(data), int'(e.v));
          chk("busy_in_done", int'(busy), 1);
        end
      end
    end
  end

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL ramp_timeout: %0d ramps pending after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
    chk("busy_after_done", int'(busy), 0);
  endtask

  task automatic issue_start(input logic [7:0] v, input bit push, output int s);
    @(posedge clk); #1;
    start = 1'b1; data_in = v; s = cyc;
    if (push) exp_q.push_back(model(v, s));
    @(posedge clk); #1;
    start = 1'b0; data_in = 8'($urandom);
  endtask

  task automatic run_normal(input logic [7:0] v, input bit poke);
    int s;
    issue_start(v, 1'b1, s);
    if (poke) begin
      // start while busy with different data must be ignored
      start = 1'b1; data_in = ~v;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_idle(400);
  endtask

  logic [7:0] dir_v [11] = '{8'd3, 8'hFE, 8'd0, 8'd20, 8'd21, 8'hEC, 8'hEB,
                             8'd127, 8'h80, 8'd1, 8'hFF};

  initial begin
    int s, tl, ti, td;
    exp_t e;
    reset = 1'b1; start = 1'b0; abort = 1'b0; data_in = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_load", int'(load), 0);
    chk("rst_inc", int'(increment), 0);
    chk("rst_dec", int'(decrement), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_status", int'(status), 0);
    chk("rst_step", int'(step_count), 0);
    reset = 1'b0;

    foreach (dir_v[i]) run_normal(dir_v[i], i[0]);

    // flag fault at the first EVAL (multi-hot flags)
    force_en = 1'b1; force_val = 3'b110;
    issue_start(8'd4, 1'b0, s);
    e = model(8'd4, s); e.n = 0; e.status = 2'b10; e.fin = 4;
    exp_q.push_back(e);
    wait_idle(400);
    force_en = 1'b0;

    // flag fault (all flags low) after one step
    issue_start(8'd6, 1'b0, s);
    e = model(8'd6, s); e.n = 1; e.status = 2'b10; e.fin = 5;
    exp_q.push_back(e);
    goto_cyc(s + 1 + P + 1);
    force_en = 1'b1; force_val = 3'b000;
    wait_idle(400);
    force_en = 1'b0;

    // abort in WAIT after the first step
    issue_start(8'd5, 1'b0, s);
    goto_cyc(s + 1 + P + 2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_step_hold", int'(step_count), 1);
    chk("abort_status_hold", int'(status), 0);
    tl = tot_load; ti = tot_inc; td = tot_dec;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_strobes", (tot_load - tl) + (tot_inc - ti) + (tot_dec - td), 0);

    // start and abort together in IDLE: abort wins
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; data_in = 8'd9; tl = tot_load;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", int'(busy), 0);
    chk("abort_start_load", int'(load), 0);
    @(posedge clk); #1;
    chk("abort_start_noload", tot_load - tl, 0);

    // reset during a STEP cycle
    issue_start(8'd5, 1'b0, s);
    goto_cyc(s + 1 + P);
    chk("in_step_dec", int'(decrement), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_dec", int'(decrement), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_data", int'(data), 0);
    chk("mid_rst_step", int'(step_count), 0);
    chk("mid_rst_status", int'(status), 0);
    run_normal(8'd2, 1'b0);

    // randomized ramps
    for (int k = 0; k < 30; k++) begin
      run_normal(8'($urandom_range(0, 60) - 30), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
